// File: rtl/uart_word_pkg.sv
// Shared definitions for the word-level UART blocks.
//   state_e      : responder FSM states
//   rx_state_e   : byte receiver states
//   build_frame  : packs a 32-bit word into four back-to-back 8N1 frames,
//                  LSB byte first, bit 0 of the result is the first bit on the line
package uart_word_pkg;

  localparam int unsigned BYTES_PER_WORD       = 4;
  localparam int unsigned BITS_PER_FRAME       = 10;
  localparam int unsigned FRAME_BITS           = BYTES_PER_WORD * BITS_PER_FRAME;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    TX_SEND
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [31:0] word);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
      f[k*BITS_PER_FRAME +: BITS_PER_FRAME] = {1'b1, word[k*8 +: 8], 1'b0};
    end
    return f;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver on an oversampled clock.
//   clk, reset   : clock, asynchronous active-high reset
//   rx           : raw serial input (asynchronous, idle high)
//   rx_busy      : a frame is being received
//   start_det    : falling edge seen while idle (start of a candidate frame)
//   byte_valid   : one-cycle pulse, byte_data holds a good byte
//   byte_data    : received byte, LSB first on the line
//   frame_err    : one-cycle pulse when the stop bit reads 0 (byte discarded)
module uart_byte_rx
  import uart_word_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_busy,
  output logic       start_det,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  assign start_det  = (state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;
  assign rx_busy    = (state_q != RX_IDLE);
  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

  // The start check falls CLKS_PER_BIT/2 samples after the synchronised edge,
  // i.e. mid start bit; every later sample is one full bit period on.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (start_det) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) byte_valid_d = 1'b1;
          else           frame_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule

// File: rtl/uart_instr_responder.sv
// Memory-side responder for the 32-bit UART word query: receives a 4-byte
// address word, reads one word from a synchronous memory, returns it as 4 bytes.
//   clk, reset : oversampled baud clock, asynchronous active-high reset
//   rx, tx     : 8N1 serial in / out, both idle high
//   mem_en     : one-cycle read strobe; mem_addr = rx_word[ADDR_W+1:2]
//   mem_rdata  : read data, valid the cycle after mem_en
//   busy       : word accepted until last stop bit of the response sent
//   frame_err  : one-cycle pulse on a bad stop bit
//   overrun    : sticky, a word completed while busy (that word is dropped)
module uart_instr_responder
  import uart_word_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              tx,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BCLK_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned FIDX_W = $clog2(FRAME_BITS + 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BCLK_W-1:0] BCLK_LAST = BCLK_W'(CLKS_PER_BIT - 1);
  localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(FRAME_BITS - 1);

  logic       rx_busy, rx_start, rx_valid, rx_ferr;
  logic [7:0] rx_byte;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_busy   (rx_busy),
    .start_det (rx_start),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (rx_ferr)
  );

  state_e                  state_q, state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [23:0]             rx_word_q, rx_word_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic                    mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    tx_q, tx_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [BCLK_W-1:0]       tx_clk_q, tx_clk_d;
  logic [FIDX_W-1:0]       tx_bit_q, tx_bit_d;

  logic        timeout;
  logic        word_done;
  logic [31:0] full_word;

  assign tx        = tx_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;
  assign frame_err = rx_ferr;
  assign overrun   = overrun_q;
  assign full_word = {rx_byte, rx_word_q};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    rx_word_d  = rx_word_q;
    to_cnt_d   = to_cnt_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;
    tx_d       = tx_q;
    frame_d    = frame_q;
    tx_clk_d   = tx_clk_q;
    tx_bit_d   = tx_bit_q;
    timeout    = 1'b0;
    word_done  = 1'b0;

    // Inter-byte timeout only runs between frames of a partial word; a start
    // edge in the expiry cycle clears the counter first, so the word survives.
    if (byte_cnt_q == 2'd0 || rx_busy || rx_start) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d = '0;
      timeout  = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    // Word assembly; the 4th byte is used straight from the receiver.
    if (rx_ferr) begin
      byte_cnt_d = 2'd0;
    end else if (rx_valid) begin
      case (byte_cnt_q)
        2'd0: rx_word_d[7:0]   = rx_byte;
        2'd1: rx_word_d[15:8]  = rx_byte;
        2'd2: rx_word_d[23:16] = rx_byte;
        default: word_done = 1'b1;
      endcase
      byte_cnt_d = byte_cnt_q + 2'd1;
    end else if (timeout) begin
      byte_cnt_d = 2'd0;
    end

    if (word_done && busy_q) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (word_done) begin
          state_d    = MEM_REQ;
          mem_en_d   = 1'b1;
          busy_d     = 1'b1;
          mem_addr_d = full_word[ADDR_W+1:2];
        end
      end
      MEM_REQ: state_d = MEM_WAIT;
      MEM_WAIT: begin
        state_d  = TX_SEND;
        frame_d  = build_frame(mem_rdata);
        tx_d     = 1'b0;
        tx_clk_d = '0;
        tx_bit_d = '0;
      end
      TX_SEND: begin
        if (tx_clk_q == BCLK_LAST) begin
          tx_clk_d = '0;
          if (tx_bit_q == FIDX_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + FIDX_W'(1);
            frame_d  = frame_q >> 1;
            tx_d     = frame_q[1];
          end
        end else begin
          tx_clk_d = tx_clk_q + BCLK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      rx_word_q  <= '0;
      to_cnt_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      tx_q       <= 1'b1;
      frame_q    <= '1;
      tx_clk_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      rx_word_q  <= rx_word_d;
      to_cnt_q   <= to_cnt_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      tx_q       <= tx_d;
      frame_q    <= frame_d;
      tx_clk_q   <= tx_clk_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

endmodule
